store_split_queue: RTL and testbench
====================================

// Module: store_split_queue
// PURPOSE
//  Store-side write formatter and buffer between the memory stage and the data bus.
//  - Queues store requests.
//  - Aligns each store's data onto BUS_BYTES-wide lanes and generates the byte strobe.
//  - Splits a store that crosses a bus-word boundary into two bus beats.
//  - Decouples the pipeline from bus back-pressure with a valid/ready handshake on both sides.
// PARAMETERS
//  BUS_BYTES  8   bus width in bytes; power of two, >=2 (data width = 8*BUS_BYTES)
//  DEPTH      4   queue entries; power of two, >=2
//  ADDR_W     64  address width
// PORTS
//  clk        in   1           clock; all state updates on the rising edge
//  resetn     in   1           asynchronous, active-low reset
//  in_valid   in   1           store request valid
//  in_ready   out  1           queue can accept a request this cycle
//  in_addr    in   ADDR_W      byte address of the store (any alignment)
//  in_data    in   8*BUS_BYTES store data, right-justified (bits [8*n-1:0] are used)
//  in_size    in   msize_t     MSIZE1/2/4/8 = 1/2/4/8 bytes; must be <= BUS_BYTES
//  out_valid  out  1           bus beat valid
//  out_ready  in   1           bus accepts the beat
//  out_addr   out  ADDR_W      bus-word-aligned beat address (low log2(BUS_BYTES) bits = 0)
//  out_data   out  8*BUS_BYTES lane-aligned beat data; unstrobed lanes are 0
//  out_strobe out  BUS_BYTES   byte-enable per lane
//  out_last   out  1           beat is the final beat of its store
//  busy       out  1           queue non-empty
// BEHAVIOUR
//  - Reset (async, resetn=0):
//    - queue empty, count=0, head/tail pointers=0, beat=FIRST;
//    - in_ready=1 once resetn=1; out_valid=0, out_strobe=0, out_data=0, out_last=0, busy=0.
//    - Reset mid-transfer drops every queued and partially sent store; no beat is replayed.
//  - Push: in_valid && in_ready stores {addr,data,size} at the tail.
//    - in_ready = (count != DEPTH).
//    - No push-through-pop when full: a full queue deasserts in_ready even if a pop occurs in the same cycle.
//  - Latency: an accepted store appears at out_valid no earlier than the next cycle (no bypass).
//  - Alignment (per head entry): off = addr mod BUS_BYTES, n = 2**size.
//    - mask2 = ((1<<n)-1) << off, over 2*BUS_BYTES lanes.
//    - data2 = data[8n-1:0] << (8*off), over 2*8*BUS_BYTES bits.
//    - cross = (off + n > BUS_BYTES).
//  - Beat state machine (per head entry):
//    - FIRST: out_addr = addr & ~(BUS_BYTES-1); strobe/data = low halves of mask2/data2; out_last = !cross.
//      - FIRST -> SECOND on out_valid && out_ready && cross.
//    - SECOND: out_addr = FIRST address + BUS_BYTES, wrapping mod 2**ADDR_W; strobe/data = high halves; out_last = 1.
//      - SECOND -> FIRST on accept.
//    - A head entry is popped when a beat with out_last=1 is accepted; beat returns to FIRST.
//  - Handshake: out_valid = busy.
//    - While out_valid && !out_ready, out_addr/out_data/out_strobe/out_last hold stable.
//  - Simultaneous push and pop when not full: count unchanged, both pointers advance; pointers wrap mod DEPTH.
//  - Aligned stores of size == BUS_BYTES always take exactly one beat with strobe all-ones.
//  - in_size > log2(BUS_BYTES) is illegal: caught by an assertion, and the RTL treats it as size = BUS_BYTES.
//  - Stores leave in program order; bytes from different entries are never merged into one beat.
// STRUCTURE
//  - common package: msize_t (existing), BUS_BYTES-derived localparams, beat_e {FIRST,SECOND}.
//  - Sub-module store_lane_align:
//    - combinational; maps {off, size, data} to {mask2, data2, cross};
//    - parametrised by BUS_BYTES; instanced once on the queue head.
//  - Top level: circular buffer, count register, beat state register, output mux.
// TESTING
//  1. BUS_BYTES=8: store addr=0x1003 size1 data=0xAB, out_ready=1
//     -> one beat: addr 0x1000, strobe 0x08, data 0x00000000AB000000, last=1.
//  2. Store addr=0x1006 size4 data=0x11223344
//     -> beat1: addr 0x1000, strobe 0xC0, data[63:48]=0x3344, last=0;
//     -> beat2: addr 0x1008, strobe 0x03, data[15:0]=0x1122, last=1.
//  3. out_ready=0, push 5 stores (DEPTH=4) -> in_ready=0 after the 4th push, 5th held;
//     raise out_ready -> beats emerge in push order, then the 5th is accepted.
//  4. Crossing store stalled in SECOND with out_ready=0 for 3 cycles -> outputs stable; pop only on accept.
//  5. resetn pulsed low between beat1 and beat2 of a crossing store
//     -> out_valid=0 immediately, busy=0, and no second beat after reset release.
//  6. addr=0xFFFF_FFFF_FFFF_FFFE size4 -> beat2 addr wraps to 0x0, strobe 0x03.

Source files
------------

// File: rtl/store_split_queue_pkg.sv
// store_split_queue_pkg
//   Shared types for the store write formatter: access size encoding,
//   beat phase of the head entry, default bus geometry and a size clamp
//   helper used by the lane aligner.
package store_split_queue_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } beat_e;

  localparam int unsigned DEF_BUS_BYTES = 8;
  localparam int unsigned DEF_OFF_W     = $clog2(DEF_BUS_BYTES);
  localparam int unsigned DEF_DATA_W    = 8 * DEF_BUS_BYTES;

  // Sizes wider than the bus are illegal; they are treated as a full bus word.
  function automatic logic [1:0] clamp_size(input msize_t size, input int unsigned max_log2);
    if (32'(size) > max_log2) return 2'(max_log2);
    return size;
  endfunction

endpackage

// File: rtl/store_split_queue_align.sv
// store_lane_align
//   Combinational lane aligner for one store. Places the right-justified
//   store bytes at byte offset i_off across a double-width (two bus word)
//   window and reports whether the store spills into the second word.
//   Ports:
//     i_off   byte offset of the store within its bus word
//     i_size  access size (clamped to the bus width)
//     i_data  right-justified store data
//     o_mask2 byte strobe over 2*BUS_BYTES lanes
//     o_data2 lane-aligned data over 2*8*BUS_BYTES bits, unstrobed lanes 0
//     o_cross store occupies lanes of the second bus word
module store_lane_align
  import store_split_queue_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 8
) (
  input  logic [$clog2(BUS_BYTES)-1:0] i_off,
  input  msize_t                       i_size,
  input  logic [8*BUS_BYTES-1:0]       i_data,
  output logic [2*BUS_BYTES-1:0]       o_mask2,
  output logic [16*BUS_BYTES-1:0]      o_data2,
  output logic                         o_cross
);

  localparam int unsigned OFF_W  = $clog2(BUS_BYTES);
  localparam int unsigned DATA_W = 8 * BUS_BYTES;

  logic [1:0]            w_size;
  logic [OFF_W:0]        w_n;
  logic [2*BUS_BYTES-1:0] w_lo_mask;
  logic [DATA_W-1:0]     w_data_m;

  assign w_size = clamp_size(i_size, OFF_W);
  assign w_n    = (OFF_W+1)'(1) << w_size;

  always_comb begin
    w_lo_mask = '0;
    w_data_m  = '0;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      if (i < 32'(w_n)) begin
        w_lo_mask[i]     = 1'b1;
        w_data_m[8*i +: 8] = i_data[8*i +: 8];
      end
    end
  end

  assign o_mask2 = w_lo_mask << i_off;
  assign o_data2 = {DATA_W'(0), w_data_m} << {i_off, 3'b000};
  assign o_cross = ({1'b0, i_off} + w_n) > (OFF_W+1)'(BUS_BYTES);

endmodule

// File: rtl/store_split_queue.sv
// store_split_queue
//   Store write formatter and buffer between the memory stage and the data
//   bus. Queues store requests in a circular buffer, aligns the head entry
//   onto bus lanes, and emits one beat (or two when the store crosses a
//   bus-word boundary) over a valid/ready handshake.
//   Ports:
//     clk, resetn           clock, asynchronous active-low reset
//     in_valid/in_ready     store request handshake
//     in_addr/data/size     store byte address, right-justified data, size
//     out_valid/out_ready   bus beat handshake
//     out_addr              bus-word-aligned beat address
//     out_data/out_strobe   lane-aligned beat data and byte enables
//     out_last              final beat of the current store
//     busy                  queue non-empty
module store_split_queue
  import store_split_queue_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [8*BUS_BYTES-1:0] in_data,
  input  msize_t                 in_size,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [8*BUS_BYTES-1:0] out_data,
  output logic [BUS_BYTES-1:0]   out_strobe,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned OFF_W  = $clog2(BUS_BYTES);
  localparam int unsigned DATA_W = 8 * BUS_BYTES;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  msize_t            r_size [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  beat_e            r_beat;
  beat_e            w_beat_nxt;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_accept;
  logic [2*BUS_BYTES-1:0] w_mask2;
  logic [2*DATA_W-1:0]    w_data2;
  logic                   w_cross;
  logic [ADDR_W-1:0]      w_base;

  assign busy      = (r_count != '0);
  assign out_valid = busy;
  assign in_ready  = (r_count != (PTR_W+1)'(DEPTH));
  assign w_push    = in_valid && in_ready;
  assign w_accept  = out_valid && out_ready;
  assign w_pop     = w_accept && out_last;

  // Storage needs no reset: every read is qualified by busy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
      r_size[r_tail] <= in_size;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_beat  <= FIRST;
    end else begin
      r_beat <= w_beat_nxt;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      assert (32'(in_size) <= OFF_W);
    end
  end

  store_lane_align #(
    .BUS_BYTES(BUS_BYTES)
  ) u_align (
    .i_off  (r_addr[r_head][OFF_W-1:0]),
    .i_size (r_size[r_head]),
    .i_data (r_data[r_head]),
    .o_mask2(w_mask2),
    .o_data2(w_data2),
    .o_cross(w_cross)
  );

  assign w_base = r_addr[r_head] & ~ADDR_W'(BUS_BYTES - 1);

  always_comb begin
    w_beat_nxt = r_beat;
    if (w_accept) begin
      case (r_beat)
        FIRST:   if (w_cross) w_beat_nxt = SECOND;
        SECOND:  w_beat_nxt = FIRST;
        default: w_beat_nxt = FIRST;
      endcase
    end
  end

  always_comb begin
    out_addr   = '0;
    out_data   = '0;
    out_strobe = '0;
    out_last   = 1'b0;
    if (busy) begin
      if (r_beat == FIRST) begin
        out_addr   = w_base;
        out_data   = w_data2[DATA_W-1:0];
        out_strobe = w_mask2[BUS_BYTES-1:0];
        out_last   = !w_cross;
      end else begin
        out_addr   = w_base + ADDR_W'(BUS_BYTES);
        out_data   = w_data2[2*DATA_W-1:DATA_W];
        out_strobe = w_mask2[2*BUS_BYTES-1:BUS_BYTES];
        out_last   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_split_queue.sv
module tb_store_split_queue;
  import store_split_queue_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_data;
  msize_t      in_size;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_addr;
  logic [63:0] out_data;
  logic [7:0]  out_strobe;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_split_queue #(
    .BUS_BYTES(8),
    .DEPTH    (4),
    .ADDR_W   (64)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_strobe(out_strobe),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    msize_t      size;
    bit          two;
    logic [63:0] a1;
    logic [7:0]  s1;
    logic [63:0] d1;
    logic [63:0] a2;
    logic [7:0]  s2;
    logic [63:0] d2;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [63:0] a, input logic [7:0] s,
                            input logic [63:0] d, input logic l);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_addr"}, out_addr, a);
    chk({tag, "_strobe"}, {56'd0, out_strobe}, {56'd0, s});
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, {63'd0, out_last}, {63'd0, l});
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] a, input logic [7:0] s,
                             input logic [63:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_beat(tag, a, s, d, l);
  endtask

  task automatic push(input string tag, input logic [63:0] a, input logic [63:0] d,
                      input msize_t sz, input bit nobypass);
    int n = 0;
    @(negedge clk);
    in_addr  = a;
    in_data  = d;
    in_size  = sz;
    in_valid = 1'b1;
    #1;
    if (nobypass) chk({tag, "_nobypass"}, {63'd0, out_valid}, 64'd0);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_push_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] q_addr[5];
    logic [63:0] q_data[5];

    vecs[0] = '{64'h1003, 64'hDEADBEEF_CAFE12AB, MSIZE1, 1'b0,
                64'h1000, 8'h08, 64'h00000000_AB000000, 64'h0, 8'h00, 64'h0};
    vecs[1] = '{64'h1006, 64'h11223344, MSIZE4, 1'b1,
                64'h1000, 8'hC0, 64'h3344_0000_0000_0000, 64'h1008, 8'h03, 64'h1122};
    vecs[2] = '{64'h2000, 64'h01234567_89ABCDEF, MSIZE8, 1'b0,
                64'h2000, 8'hFF, 64'h01234567_89ABCDEF, 64'h0, 8'h00, 64'h0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hAABBCCDD, MSIZE4, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF8, 8'hC0, 64'hCCDD_0000_0000_0000, 64'h0, 8'h03, 64'hAABB};
    vecs[4] = '{64'h3007, 64'hBEEF, MSIZE2, 1'b1,
                64'h3000, 8'h80, 64'hEF00_0000_0000_0000, 64'h3008, 8'h01, 64'hBE};
    vecs[5] = '{64'h4004, 64'h55667788, MSIZE4, 1'b0,
                64'h4000, 8'hF0, 64'h55667788_00000000, 64'h0, 8'h00, 64'h0};
    vecs[6] = '{64'h5001, 64'h11223344_55667788, MSIZE8, 1'b1,
                64'h5000, 8'hFE, 64'h22334455_66778800, 64'h5008, 8'h01, 64'h11};
    vecs[7] = '{64'h6002, 64'hFFFFFFFF_FFFFA5C3, MSIZE2, 1'b0,
                64'h6000, 8'h0C, 64'h00000000_A5C30000, 64'h0, 8'h00, 64'h0};

    q_addr = '{64'h100, 64'h208, 64'h310, 64'h418, 64'h520};
    q_data = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333,
               64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_size   = MSIZE1;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_strobe", {56'd0, out_strobe}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single stores, bus always ready.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      push(tag, vecs[i].addr, vecs[i].data, vecs[i].size, 1'b1);
      expect_beat({tag, "b1"}, vecs[i].a1, vecs[i].s1, vecs[i].d1, !vecs[i].two);
      if (vecs[i].two)
        expect_beat({tag, "b2"}, vecs[i].a2, vecs[i].s2, vecs[i].d2, 1'b1);
      @(negedge clk);
      chk({tag, "_drained"}, {63'd0, busy}, 64'd0);
    end

    // Fill to DEPTH with the bus stalled, hold a fifth store, then drain.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push($sformatf("fill%0d", k), q_addr[k], q_data[k], MSIZE8, 1'b0);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    in_addr  = q_addr[4];
    in_data  = q_data[4];
    in_size  = MSIZE8;
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("held_in_ready", {63'd0, in_ready}, 64'd0);
      check_beat("held_head", q_addr[0], 8'hFF, q_data[0], 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_frees_slot", {63'd0, in_ready}, 64'd1);
    check_beat("order1", q_addr[1], 8'hFF, q_data[1], 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 2; k < 5; k++)
      expect_beat($sformatf("order%0d", k), q_addr[k], 8'hFF, q_data[k], 1'b1);
    @(negedge clk);
    chk("fill_drained", {63'd0, busy}, 64'd0);

    // Crossing store stalled in its second beat.
    out_ready = 1'b1;
    push("stall", 64'h1006, 64'h11223344, MSIZE4, 1'b0);
    expect_beat("stall_b1", 64'h1000, 8'hC0, 64'h3344_0000_0000_0000, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_beat($sformatf("stall_b2_%0d", j), 64'h1008, 8'h03, 64'h1122, 1'b1);
      chk("stall_busy", {63'd0, busy}, 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_popped", {63'd0, busy}, 64'd0);

    // Reset between the two beats of a crossing store.
    push("rst_mid", 64'h3007, 64'hBEEF, MSIZE2, 1'b0);
    expect_beat("rst_mid_b1", 64'h3000, 8'h80, 64'hEF00_0000_0000_0000, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_strobe", {56'd0, out_strobe}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("post_rst_no_beat", {63'd0, out_valid}, 64'd0);
    end
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
